// File: rtl/rng_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the rng_stream block.
package rng_pkg;

    localparam int WORDSIZE = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } rng_state_e;

    // Galois right-shift feedback masks known to be maximal-length.
    // Widths without an entry return zero and must be given an explicit POLY.
    function automatic logic [63:0] default_poly(input int width);
        case (width)
            4:       default_poly = 64'h0000_0000_0000_000C;
            5:       default_poly = 64'h0000_0000_0000_0014;
            6:       default_poly = 64'h0000_0000_0000_0030;
            7:       default_poly = 64'h0000_0000_0000_0060;
            8:       default_poly = 64'h0000_0000_0000_00B8;
            16:      default_poly = 64'h0000_0000_0000_B400;
            32:      default_poly = 64'h0000_0000_8020_0003;
            64:      default_poly = 64'hD800_0000_0000_0000;
            default: default_poly = 64'h0;
        endcase
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// Show-ahead word buffer with synchronous flush; head is forced to zero when empty.
module rng_fifo
    import rng_pkg::*;
#(
    parameter int WIDTH = WORDSIZE,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A full buffer still accepts a word when the head leaves on the same edge.
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/rng_stream.sv
// Galois LFSR word generator feeding a show-ahead buffer, with seed load/flush
// and backpressure that stalls the LFSR rather than dropping words.
module rng_stream
    import rng_pkg::*;
#(
    parameter int               WIDTH        = WORDSIZE,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
    parameter int               DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          seed_we,
    input  logic [WIDTH-1:0]              seed,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              dataout,
    output logic                          ready,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int CW = cnt_width(DEPTH);

    rng_state_e       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic             full, push, pop;

    assign full  = (count == CW'(DEPTH));
    assign ready = (count != '0);
    assign pop   = ready && out_ready && !seed_we;
    assign push  = en && !seed_we && (!full || pop);

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_we)   lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
        else if (push) lfsr_d = lfsr_step;
    end

    always_comb begin
        state_d = state_q;
        if (seed_we)          state_d = en ? RUN : IDLE;
        else if (!en)         state_d = IDLE;
        else if (full && !pop) state_d = STALL;
        else                  state_d = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q  <= SEED_DEFAULT;
            state_q <= IDLE;
        end else begin
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
        end
    end

    rng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (seed_we),
        .push  (push),
        .pop   (pop),
        .wdata (lfsr_q),
        .rdata (dataout),
        .count (count)
    );

endmodule

// File: tb/tb_rng_stream.sv
// Directed bench for rng_stream at WIDTH=8, POLY=B8, DEPTH=4.
module tb_rng_stream;
    import rng_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       seed_we = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] dataout;
    logic       ready;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    rng_stream #(
        .WIDTH        (8),
        .POLY         (8'hB8),
        .SEED_DEFAULT (8'h01),
        .DEPTH        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .seed_we   (seed_we),
        .seed      (seed),
        .out_ready (out_ready),
        .dataout   (dataout),
        .ready     (ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; seed_we = 1'b0; seed = 8'h00; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (dataout !== 8'h00) begin bad++; $display("FAIL reset_dataout got=%h want=00", dataout); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (dut.lfsr_q !== 8'h01) begin bad++; $display("FAIL reset_lfsr got=%h want=01", dut.lfsr_q); end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=IDLE", dut.state_q); end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        logic [7:0] exp [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (dataout !== exp[i] || ready !== 1'b1) begin
                bad++; $display("FAIL seq[%0d] got=%h/%b want=%h/1", i, dataout, ready, exp[i]);
            end
        end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL seq_count got=%0d want=1", count); end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d want=4", count); end
        total++; if (dut.state_q !== STALL) begin bad++; $display("FAIL bp_state got=%0d want=STALL", dut.state_q); end
        total++; if (dut.lfsr_q !== 8'h17) begin bad++; $display("FAIL bp_lfsr_hold got=%h want=17", dut.lfsr_q); end
        total++; if (dataout !== exp[0]) begin bad++; $display("FAIL bp_head got=%h want=01", dataout); end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            total++;
            if (dataout !== exp[i] || count !== 3'd4) begin
                bad++; $display("FAIL bp_drain[%0d] got=%h cnt=%0d want=%h cnt=4", i, dataout, count, exp[i]);
            end
        end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_zero_seed();
        en = 1'b1; out_ready = 1'b1; seed_we = 1'b1; seed = 8'h00;
        tick();
        seed_we = 1'b0;
        total++; if (ready !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL zseed_flush got=%b/%0d want=0/0", ready, count);
        end
        total++; if (dataout !== 8'h00) begin bad++; $display("FAIL zseed_dout_empty got=%h want=00", dataout); end
        tick();
        total++; if (dataout !== 8'h01) begin bad++; $display("FAIL zseed_w0 got=%h want=01", dataout); end
        tick();
        total++; if (dataout !== 8'hB8) begin bad++; $display("FAIL zseed_w1 got=%h want=B8", dataout); end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [7:0] exp [3] = '{8'h5C, 8'h2E, 8'h17};
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d want=3", count); end
        seed_we = 1'b1; seed = 8'h5C; out_ready = 1'b1;
        tick();
        seed_we = 1'b0;
        total++; if (count !== 3'd0 || ready !== 1'b0) begin
            bad++; $display("FAIL flush_count got=%0d/%b want=0/0", count, ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (dataout !== exp[i]) begin bad++; $display("FAIL flush_w[%0d] got=%h want=%h", i, dataout, exp[i]); end
        end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2 reset = 1'b1;
        #1;
        total++; if (ready !== 1'b0 || dataout !== 8'h00 || count !== 3'd0) begin
            bad++; $display("FAIL areset_now got=%b/%h/%0d want=0/00/0", ready, dataout, count);
        end
        tick();
        reset = 1'b0;
        tick();
        total++; if (dataout !== 8'h01 || count !== 3'd1) begin
            bad++; $display("FAIL areset_first got=%h/%0d want=01/1", dataout, count);
        end
        en = 1'b0;
    endtask

    task automatic test_en_off();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        en = 1'b0;
        tick();
        total++; if (count !== 3'd2 || dut.lfsr_q !== 8'h5C) begin
            bad++; $display("FAIL enoff_hold got=%0d/%h want=2/5C", count, dut.lfsr_q);
        end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL enoff_state got=%0d want=IDLE", dut.state_q); end
        out_ready = 1'b1;
        tick();
        total++; if (dataout !== 8'hB8 || count !== 3'd1) begin
            bad++; $display("FAIL enoff_drain1 got=%h/%0d want=B8/1", dataout, count);
        end
        tick();
        total++; if (ready !== 1'b0 || dataout !== 8'h00) begin
            bad++; $display("FAIL enoff_empty got=%b/%h want=0/00", ready, dataout);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_period();
        logic [255:0] seen;
        logic [7:0]   exp;
        logic [7:0]   first;
        int           dup, zero, mis;
        seen = '0; dup = 0; zero = 0; mis = 0; exp = 8'h01; first = 8'h00;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 0) first = dataout;
            if (dataout !== exp) mis++;
            exp = (exp >> 1) ^ (exp[0] ? 8'hB8 : 8'h00);
            if (i < 255) begin
                if (dataout == 8'h00) zero++;
                if (seen[dataout]) dup++;
                seen[dataout] = 1'b1;
            end else begin
                total++; if (dataout !== first) begin bad++; $display("FAIL period_wrap got=%h want=%h", dataout, first); end
            end
        end
        total++; if (mis != 0) begin bad++; $display("FAIL period_model got=%0d want=0 mismatched words", mis); end
        total++; if (dup != 0) begin bad++; $display("FAIL period_distinct got=%0d want=0 repeats", dup); end
        total++; if (zero != 0) begin bad++; $display("FAIL period_nonzero got=%0d want=0 zeros", zero); end
        en = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_zero_seed();
        test_flush();
        test_async_reset();
        test_en_off();
        test_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_stream.md
RNG_STREAM -- requirements
Module: rng_stream

Interface
REQ-001 Parameter WIDTH, default WORDSIZE (shared constants), LFSR and output word width; legal range 4..64.
REQ-002 Parameter POLY, default 32'h80200003, Galois feedback mask of WIDTH bits; it must be maximal-length for WIDTH.
REQ-003 Parameter SEED_DEFAULT, default 1, LFSR value after reset; it must be nonzero.
REQ-004 Parameter DEPTH, default 4, output buffer depth; it must be a power of two and at least 2.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port en, input, 1 bit: generation enable.
REQ-008 Port seed_we, input, 1 bit: seed load strobe.
REQ-009 Port seed, input, WIDTH bits: seed value.
REQ-010 Port out_ready, input, 1 bit: consumer accept.
REQ-011 Port dataout, output, WIDTH bits: random word at the buffer head.
REQ-012 Port ready, output, 1 bit: dataout valid (buffer not empty).
REQ-013 Port count, output, $clog2(DEPTH+1) bits: buffer occupancy.

Function
REQ-014 LFSR step SHALL be Galois right-shift: next = (s>>1) ^ (s[0] ? POLY : 0).
REQ-015 Push SHALL occur on an edge when en=1, seed_we=0, and (count<DEPTH or a pop occurs on the same edge); the current LFSR value is written and the LFSR advances one step.
REQ-016 When no push occurs, the LFSR SHALL hold its value.
REQ-017 Pop SHALL occur on an edge when ready=1 and out_ready=1.
REQ-018 Latency SHALL be one cycle: en sampled high at edge k with an empty buffer gives ready=1 after edge k.
REQ-019 ready SHALL equal (count != 0).
REQ-020 dataout SHALL equal the buffer head while ready=1, and SHALL be zero while ready=0.
REQ-021 dataout SHALL hold stable while ready=1 and out_ready=0.
REQ-022 Simultaneous push and pop SHALL both take effect with count unchanged, including at count=DEPTH.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Full condition: with count=DEPTH and no pop, no push occurs and the LFSR holds, so no word is skipped.
REQ-025 Seed load: seed_we=1 at an edge SHALL load the LFSR with seed, or with 1 if seed=0; flush the buffer (count=0, ready=0); suppress any push; ignore out_ready.
REQ-026 seed_we SHALL take priority over en and out_ready.
REQ-027 Deasserting en SHALL stop pushes but retain buffered words, which remain drainable.
REQ-028 Control FSM SHALL have three states:
- IDLE (en=0)
- RUN (en=1 and push possible)
- STALL (en=1, count=DEPTH, no pop)
REQ-029 FSM transitions SHALL be evaluated every edge from en, count and pop; seed_we forces IDLE if en=0, else RUN.
REQ-030 The LFSR SHALL never reach the all-zero state.
REQ-031 Period SHALL be 2^WIDTH-1 words with a maximal POLY.

Reset
REQ-032 Asserting reset SHALL immediately set: LFSR=SEED_DEFAULT, pointers=0, count=0, ready=0, dataout=0, FSM=IDLE.
REQ-033 Reset mid-stream SHALL discard all buffered words.
REQ-034 After reset release, the first pushed word SHALL be SEED_DEFAULT.
REQ-035 Reset SHALL be released synchronously to clk by the environment.

Structure
REQ-036 Shared package rng_pkg SHALL hold the FSM state enum, a default maximal-polynomial table indexed by width, and the width-of-count function.
REQ-037 Buffer SHALL be a separate sub-module rng_fifo (show-ahead, parameters WIDTH and DEPTH, push/pop/count).
REQ-038 The LFSR and FSM SHALL reside in rng_stream.

Verification
REQ-039 Sequence: WIDTH=8, POLY=8'hB8, seed 8'h01, en=1, out_ready=1 -> dataout 01, B8, 5C, 2E, 17 on consecutive cycles.
REQ-040 Backpressure: out_ready=0, en=1, DEPTH=4 -> count reaches 4, FSM=STALL, LFSR holds; then out_ready=1 -> words 01, B8, 5C, 2E, 17 with no gap or duplicate.
REQ-041 Zero seed: seed_we with seed=0 -> next words 01, B8; ready=0 on the cycle after the load.
REQ-042 Flush: count=3, seed_we with seed 8'h5C -> count=0 next cycle, then stream 5C, 2E, 17.
REQ-043 Async reset mid-stream: reset pulse between edges -> ready=0 and dataout=0 immediately; first word after release is 01.
REQ-044 Period: WIDTH=8 free-run for 255 words -> all values distinct and nonzero; word 256 equals word 1.
